// File: rtl/program_counter.sv
// Program counter for the bus-based computer: counts, loads jump targets from the bus,
// and drives its value onto the shared bus through a tri-state stage gated by co.
module program_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    input  logic             j,
    input  logic             co,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic             carry;
    logic             wrap_q;

    // The carry out of the increment exists only to flag the all-ones to zero rollover.
    assign {carry, cnt_inc} = {1'b0, cnt} + (WIDTH + 1)'(1);

    // Jump outranks count; any edge that is not a wrapping increment clears the flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt    <= '0;
            wrap_q <= 1'b0;
        end else if (j) begin
            // NOTE: non-blocking so every register samples pre-edge values of cnt.
            cnt    <= bus_in;
            wrap_q <= 1'b0;
        end else if (ce) begin
            cnt    <= cnt_inc;
            wrap_q <= carry;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign count   = cnt;
    assign wrap    = wrap_q;
    assign bus_out = co ? cnt : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural counter model.
module tb_program_counter;

    localparam int WIDTH = 4;
    localparam int MAX   = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             ce;
    logic             j;
    logic             co;
    logic [WIDTH-1:0] bus_in;

    // Two identical instances: one bus pulled up, one pulled down. A released bus
    // reads all ones on the first and all zeros on the second.
    wire  [WIDTH-1:0] bus_pu;
    wire  [WIDTH-1:0] bus_pd;
    logic [WIDTH-1:0] count_pu;
    logic [WIDTH-1:0] count_pd;
    logic             wrap_pu;
    logic             wrap_pd;

    int checks = 0;
    int errors = 0;

    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    program_counter #(.WIDTH(WIDTH)) dut_pu (
        .clk(clk), .clr_n(clr_n), .ce(ce), .j(j), .co(co), .bus_in(bus_in),
        .bus_out(bus_pu), .count(count_pu), .wrap(wrap_pu)
    );

    program_counter #(.WIDTH(WIDTH)) dut_pd (
        .clk(clk), .clr_n(clr_n), .ce(ce), .j(j), .co(co), .bus_in(bus_in),
        .bus_out(bus_pd), .count(count_pd), .wrap(wrap_pd)
    );

    for (genvar b = 0; b < WIDTH; b++) begin : g_pull
        pullup   (bus_pu[b]);
        pulldown (bus_pd[b]);
    end

    always #5 clk = ~clk;

    // Behavioural model: plain modular arithmetic on an integer.
    always @(posedge clk) begin
        if (clr_n === 1'b1) begin
            if (j) begin
                m_cnt  <= int'(bus_in);
                m_wrap <= 1'b0;
            end else if (ce) begin
                m_cnt  <= (m_cnt + 1) % (MAX + 1);
                m_wrap <= (m_cnt == MAX);
            end else begin
                m_wrap <= 1'b0;
            end
        end
    end

    always @(negedge clr_n) begin
        m_cnt  <= 0;
        m_wrap <= 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bus(input string name, input int exp);
        if (co) begin
            check({name, "_pu"}, 32'(bus_pu), 32'(exp));
            check({name, "_pd"}, 32'(bus_pd), 32'(exp));
        end else begin
            check({name, "_rel_pu"}, 32'(bus_pu), 32'(MAX));
            check({name, "_rel_pd"}, 32'(bus_pd), 32'd0);
        end
    endtask

    task automatic check_state(input string name, input int exp_cnt, input bit exp_wrap);
        check({name, "_count"}, 32'(count_pu), 32'(exp_cnt));
        check({name, "_count2"}, 32'(count_pd), 32'(exp_cnt));
        check({name, "_wrap"}, 32'(wrap_pu), 32'(exp_wrap));
        check({name, "_wrap2"}, 32'(wrap_pd), 32'(exp_wrap));
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        check_state("model", m_cnt, m_wrap);
        check_bus("model_bus", m_cnt);
    end

    // Advance to just after the next falling edge, safely between rising edges.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        #2;
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n  = 1'b0;
        ce     = 1'b0;
        j      = 1'b0;
        co     = 1'b0;
        bus_in = '0;
        tick();
        check_state("reset", 0, 1'b0);
        check_bus("reset_bus", 0);
        clr_n = 1'b1;

        // Count 17 edges from zero: 1..15, 0 with wrap, then 1.
        ce = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check_state($sformatf("count_%0d", k), k % 16, k == 16);
        end
        ce = 1'b0;

        // Asynchronous reset mid-cycle after reaching 5.
        do_reset();
        ce = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check_state("pre_reset", 5, 1'b0);
        #1;
        clr_n = 1'b0;
        #1;
        check_state("async_reset", 0, 1'b0);
        check_bus("async_reset_bus_co0", 0);
        co = 1'b1;
        #1;
        check_bus("async_reset_bus_co1", 0);
        tick();
        check_state("reset_held_edge", 0, 1'b0);
        co    = 1'b0;
        clr_n = 1'b1;

        // Jump outranks count at 3.
        for (int k = 0; k < 3; k++) tick();
        check_state("at_three", 3, 1'b0);
        j      = 1'b1;
        bus_in = 4'b1010;
        tick();
        check_state("jump_priority", 10, 1'b0);
        j = 1'b0;
        tick();
        check_state("after_jump_inc", 11, 1'b0);
        ce = 1'b0;

        // Tri-state: co toggles between edges at count 6.
        j      = 1'b1;
        bus_in = 4'b0110;
        tick();
        j = 1'b0;
        #1;
        check_bus("tri_off1", 6);
        co = 1'b1;
        #1;
        check_bus("tri_on", 6);
        check_state("tri_on_state", 6, 1'b0);
        co = 1'b0;
        #1;
        check_bus("tri_off2", 6);
        check_state("tri_off_state", 6, 1'b0);

        // Hold at 9 for 4 edges.
        j      = 1'b1;
        bus_in = 4'b1001;
        tick();
        j = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_state($sformatf("hold_%0d", k), 9, 1'b0);
        end

        // Jump to all ones, then one increment wraps.
        j      = 1'b1;
        bus_in = 4'b1111;
        tick();
        check_state("jump_max", 15, 1'b0);
        j  = 1'b0;
        ce = 1'b1;
        tick();
        check_state("max_wrap", 0, 1'b1);
        ce = 1'b0;
        tick();
        check_state("max_wrap_clear", 0, 1'b0);

        // Randomized run, including self-loads and occasional mid-cycle resets.
        for (int k = 0; k < 400; k++) begin
            ce     = 1'($urandom_range(0, 3) != 0);
            j      = 1'($urandom_range(0, 4) == 0);
            co     = 1'($urandom_range(0, 1));
            bus_in = 4'($urandom_range(0, MAX));
            if ($urandom_range(0, 39) == 0) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
